// File: rtl/sriz_pkg.sv
// Shared types and constants for the multi-cycle sriz core sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sriz_pkg;

    localparam int          ILEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [3:0] {
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT,
        ERR
    } mc_state_t;

    // States that wait on a memory handshake and are therefore bounded by the timeout.
    function automatic logic is_wait_state(input mc_state_t s);
        return (s == FETCH_REQ) || (s == FETCH_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/sriz_mc_if.sv
// Instruction and data memory handshake bundle between the sequencer and memory.
// Latency: n/a (wires only).
// Backpressure: request valid is held by the master until the slave raises ready.
interface sriz_mc_if #(
    parameter int XLEN = 32
);
    import sriz_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    logic            dmem_req_valid;
    logic            dmem_wen;
    logic            dmem_req_ready;
    logic            dmem_rsp_valid;

    modport master (
        output imem_req_valid, imem_addr, dmem_req_valid, dmem_wen,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dmem_req_ready, dmem_rsp_valid
    );

    modport slave (
        input  imem_req_valid, imem_addr, dmem_req_valid, dmem_wen,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dmem_req_ready, dmem_rsp_valid
    );

endinterface

// File: rtl/sriz_wait_cnt.sv
// Handshake wait counter: expired is high during the TIMEOUT-th consecutive enabled cycle.
// Latency: expired is a decode of the registered count, no input-to-output path except en.
// Backpressure: n/a; clr restarts the count, the count freezes once expired.
module sriz_wait_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int           W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Count completed cycles in the current wait state; restart on every state change
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sriz_mc.sv
// Multi-cycle core sequencer: owns pc/ir/instret and steps IDU/EXU through fetch, memory and writeback.
// Latency: 5 cycles ALU/jump, 6 store, 7 load with zero-wait memory; every stall cycle adds one.
// Backpressure: holds req valid with stable addr/wen until ready; a wait state lasting TIMEOUT cycles parks in ERR.
module sriz_mc
    import sriz_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    sriz_mc_if.master        mem,
    output logic [ILEN-1:0]  ir,
    output logic [XLEN-1:0]  pc,
    input  logic             dec_mem,
    input  logic             dec_store,
    input  logic             dec_rf_wen,
    input  logic             dec_jump,
    input  logic             dec_halt,
    input  logic [XLEN-1:0]  exu_nextpc,
    output logic             rf_wen,
    output logic             rf_wsel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             err
);
    mc_state_t       state;
    mc_state_t       state_nxt;
    mc_state_t       wb_tgt;
    logic            run;
    logic            expired;
    logic            misalign;
    logic            wait_clr;
    logic            wait_en;
    logic [XLEN-1:0] jump_tgt;

    // Bit 0 of a jump target is always dropped; bit 1 set means a misaligned 4-byte fetch.
    assign jump_tgt = exu_nextpc & ~XLEN'(1);
    assign misalign = dec_jump & jump_tgt[1];
    assign wb_tgt   = misalign ? ERR : WB;

    assign mem.imem_addr = pc;

    assign wait_clr = (state_nxt != state);
    assign wait_en  = run && is_wait_state(state);

    sriz_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (expired)
    );

    // State register; run keeps strobes low in the cycle right after a reset edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH_REQ;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    // Next-state selection and state-decoded strobes
    always_comb begin
        state_nxt          = state;
        mem.imem_req_valid = 1'b0;
        mem.dmem_req_valid = 1'b0;
        mem.dmem_wen       = 1'b0;
        rf_wen             = 1'b0;
        rf_wsel            = 1'b0;
        retire             = 1'b0;
        halted             = 1'b0;
        err                = 1'b0;
        unique case (state)
            FETCH_REQ: begin
                mem.imem_req_valid = run;
                if (run && mem.imem_req_ready) begin
                    state_nxt = FETCH_WAIT;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            FETCH_WAIT: begin
                if (mem.imem_rsp_valid) begin
                    state_nxt = DECODE;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            DECODE: begin
                state_nxt = dec_halt ? HALT : EXEC;
            end
            EXEC: begin
                state_nxt = dec_mem ? MEM_REQ : wb_tgt;
            end
            MEM_REQ: begin
                mem.dmem_req_valid = 1'b1;
                mem.dmem_wen       = dec_store;
                if (mem.dmem_req_ready) begin
                    state_nxt = dec_store ? wb_tgt : MEM_WAIT;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            MEM_WAIT: begin
                if (mem.dmem_rsp_valid) begin
                    state_nxt = wb_tgt;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            WB: begin
                rf_wen    = dec_rf_wen;
                rf_wsel   = dec_mem & ~dec_store;
                retire    = 1'b1;
                state_nxt = FETCH_REQ;
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                state_nxt = ERR;
            end
        endcase
    end

    // Architectural registers: ir captured on fetch response, pc and instret advance only in WB
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            instret <= '0;
        end else begin
            if ((state == FETCH_WAIT) && mem.imem_rsp_valid) begin
                ir <= mem.imem_rsp_data;
            end
            if (state == WB) begin
                pc      <= dec_jump ? jump_tgt : pc + XLEN'(4);
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sriz_mc.sv
// Self-checking bench for sriz_mc: directed scenarios plus randomized instruction mixes.
// Latency: expected cycle counts are derived from per-instruction stall/latency choices.
// Backpressure: the bench plays both memories with randomized ready stalls and response delays.
module tb_sriz_mc;
    import sriz_pkg::*;

    localparam int          XLEN = 32;
    localparam int          TO   = 4;
    localparam int          CW   = 4;
    localparam logic [31:0] RPC  = 32'h8000_0000;

    localparam int K_ALU  = 0;
    localparam int K_JMP  = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_HALT = 4;
    localparam int K_BADJ = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   ir;
    logic [31:0]   pc;
    logic [31:0]   exu_nextpc;
    logic          dec_mem, dec_store, dec_rf_wen, dec_jump, dec_halt;
    logic          rf_wen, rf_wsel, retire, halted, err;
    logic [CW-1:0] instret;

    logic [31:0]   m_pc;
    int            m_instret;
    int            n_chk;
    int            n_pass;

    always #5 clk = ~clk;

    sriz_mc_if #(.XLEN(XLEN)) bus ();

    sriz_mc #(
        .XLEN     (XLEN),
        .RESET_PC (RPC),
        .TIMEOUT  (TO),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .ir         (ir),
        .pc         (pc),
        .dec_mem    (dec_mem),
        .dec_store  (dec_store),
        .dec_rf_wen (dec_rf_wen),
        .dec_jump   (dec_jump),
        .dec_halt   (dec_halt),
        .exu_nextpc (exu_nextpc),
        .rf_wen     (rf_wen),
        .rf_wsel    (rf_wsel),
        .retire     (retire),
        .instret    (instret),
        .halted     (halted),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        dec_mem = 0; dec_store = 0; dec_rf_wen = 0; dec_jump = 0; dec_halt = 0;
        exu_nextpc = '0;
        @(negedge clk);
        m_pc      = RPC;
        m_instret = 0;
        chk("rst_pc", pc, m_pc);
        chk("rst_ir", ir, 0);
        chk("rst_instret", instret, m_instret);
        chk("rst_strobes", {bus.imem_req_valid, bus.dmem_req_valid, bus.dmem_wen,
                            rf_wen, rf_wsel, retire, halted, err}, 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One instruction from its FETCH_REQ cycle to retire/err/halt (or an abort by reset).
    // is_/il: imem ready stall and response delay; ds/dl: same for dmem.
    task automatic do_instr(input int kind, input logic [31:0] tgt, input int is_, input int il,
                            input int ds, input int dl, input bit wen, input bit abort);
        logic [31:0] word;
        int  lat, exp_lat, dcnt, acc_cyc, n_wen;
        bit  acc, done, aborted, is_ld, is_st, is_mem, is_jmp;
        is_ld  = (kind == K_LD);
        is_st  = (kind == K_ST);
        is_mem = is_ld || is_st;
        is_jmp = (kind == K_JMP) || (kind == K_BADJ);
        word   = $urandom;
        dec_mem = is_mem; dec_store = is_st; dec_jump = is_jmp;
        dec_halt = (kind == K_HALT); dec_rf_wen = wen; exu_nextpc = tgt;

        chk("ireq_vld", bus.imem_req_valid, 1);
        chk("imem_addr", bus.imem_addr, m_pc);
        lat = 1;
        bus.imem_req_ready = (is_ == 0);
        for (int i = 0; i < is_; i++) begin
            @(negedge clk); lat++;
            bus.imem_req_ready = (i == is_ - 1);
        end
        if (is_ > 0) chk("ireq_hold", {bus.imem_req_valid, bus.imem_addr}, {1'b1, m_pc});
        @(negedge clk); lat++;
        bus.imem_req_ready = 1'b0;
        repeat (il - 1) begin @(negedge clk); lat++; end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word;
        @(negedge clk); lat++;

        dcnt = 0; acc = 0; acc_cyc = 0; done = 0; aborted = 0; n_wen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 1) chk("ir_hold", ir, word);
            n_wen += int'(rf_wen);
            if (abort && acc && lat == acc_cyc + 1) begin
                aborted = 1; done = 1;
            end else if (retire || err || halted) begin
                done = 1;
            end else begin
                // stray responses outside the wait states must be ignored
                bus.imem_rsp_valid = (c == 0);
                bus.imem_rsp_data  = ~word;
                bus.dmem_rsp_valid = (c == 0) || (is_ld && acc && lat == acc_cyc + dl);
                bus.dmem_req_ready = 1'b0;
                if (bus.dmem_req_valid) begin
                    chk("dmem_wen", bus.dmem_wen, is_st);
                    if (dcnt == ds) begin
                        bus.dmem_req_ready = 1'b1;
                        acc = 1; acc_cyc = lat;
                    end
                    dcnt++;
                end
                @(negedge clk); lat++;
            end
        end
        bus.imem_rsp_valid = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_req_ready = 1'b0;
        if (!done) chk("done_in_budget", 0, 1);

        if (aborted) begin
            chk("abort_in_wait", {bus.dmem_req_valid, retire}, 2'b00);
            rst = 1'b0;
            @(negedge clk);
            m_pc = RPC; m_instret = 0;
            chk("abort_no_retire", {retire, rf_wen}, 2'b00);
            chk("abort_pc", pc, m_pc);
            chk("abort_instret", instret, m_instret);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_refetch", {bus.imem_req_valid, bus.imem_addr}, {1'b1, m_pc});
            return;
        end

        exp_lat = is_ + 1 + il + 1;
        if (kind == K_HALT) exp_lat += 1;
        else exp_lat += 2 + (is_mem ? ds + 1 : 0) + (is_ld ? dl : 0);
        chk("latency", lat, exp_lat);
        chk("dreq_cycles", dcnt, is_mem ? ds + 1 : 0);

        if (kind == K_HALT) begin
            chk("halted", {halted, err, retire}, 3'b100);
            @(negedge clk);
            chk("halt_sticky", {halted, bus.imem_req_valid, bus.dmem_req_valid}, 3'b100);
            chk("halt_instret", instret, m_instret);
        end else if (kind == K_BADJ) begin
            chk("badj_err", {err, retire, rf_wen}, 3'b100);
            repeat (3) @(negedge clk);
            chk("badj_quiet", {err, bus.imem_req_valid, bus.dmem_req_valid, rf_wen, retire}, 5'b10000);
            chk("badj_pc", pc, m_pc);
            chk("badj_instret", instret, m_instret);
        end else begin
            chk("retire", {retire, err}, 2'b10);
            chk("rf_wen_count", n_wen, wen);
            chk("rf_wsel", rf_wsel, is_ld);
            m_pc      = is_jmp ? (tgt & 32'hFFFF_FFFE) : m_pc + 32'd4;
            m_instret = (m_instret + 1) % (1 << CW);
            @(negedge clk);
            chk("retire_pulse", retire, 0);
            chk("pc", pc, m_pc);
            chk("instret", instret, m_instret);
        end
    endtask

    task automatic fetch_timeout();
        int n;
        chk("to_ireq", bus.imem_req_valid, 1);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        n = 1;
        while (!err && n < 50) begin
            @(negedge clk); n++;
        end
        chk("to_cycles", n, TO + 1);
        bus.imem_rsp_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        chk("to_quiet", {err, bus.imem_req_valid, bus.dmem_req_valid, rf_wen, retire, halted}, 6'b100000);
        chk("to_pc", pc, m_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        do_reset();
        do_instr(K_ALU, 32'h0, 0, 1, 0, 1, 1, 0);
        do_instr(K_JMP, 32'h8000_0101, 0, 1, 0, 1, 1, 0);
        do_instr(K_BADJ, 32'h8000_0102, 0, 1, 0, 1, 1, 0);
        do_reset();
        do_instr(K_LD, 32'h0, 0, 1, 3, 2, 1, 0);
        do_instr(K_ST, 32'h0, 0, 1, 0, 1, 0, 0);
        do_instr(K_ALU, 32'h0, TO - 1, TO, 0, 1, 1, 0);
        do_instr(K_LD, 32'h0, 0, 1, TO - 1, TO, 1, 0);
        do_instr(K_JMP, 32'hFFFF_FFFD, 1, 2, 0, 1, 0, 0);
        do_instr(K_ALU, 32'h0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] t;
            bit          w;
            k    = $urandom_range(0, 3);
            t    = $urandom;
            t[1] = 1'b0;
            w    = ($urandom_range(0, 1) != 0);
            do_instr(k, t, $urandom_range(0, TO - 1), $urandom_range(1, TO),
                     $urandom_range(0, TO - 1), $urandom_range(1, TO), w, 0);
        end
        do_reset();
        fetch_timeout();
        do_reset();
        do_instr(K_ALU, 32'h0, 0, 1, 0, 1, 1, 0);
        do_instr(K_HALT, 32'h0, 0, 1, 0, 1, 0, 0);
        do_reset();
        do_instr(K_ALU, 32'h0, 0, 1, 0, 1, 1, 0);
        do_instr(K_LD, 32'h0, 0, 1, 1, 3, 1, 1);
        do_instr(K_ALU, 32'h0, 0, 1, 0, 1, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
